// File: rtl/timer_package.sv
// Shared types and constants for the programmable timer.
// Holds the FSM state encoding, the reload mode encoding and the default width.
package timer_package;

    localparam int unsigned DEFAULT_BIT_COUNT = 32;

    typedef enum logic [1:0] {
        STATE_IDLE    = 2'd0,
        STATE_RUNNING = 2'd1,
        STATE_EXPIRED = 2'd2
    } timer_state_t;

    typedef enum logic {
        MODE_ONE_SHOT = 1'b0,
        MODE_PERIODIC = 1'b1
    } timer_mode_t;

endpackage

// File: rtl/programmable_timer.sv
// Programmable up-counter with one-shot and auto-reload modes.
// The FSM tracks IDLE/RUNNING/EXPIRED; a separate datapath owns count and done.
module programmable_timer
    import timer_package::*;
#(
    parameter int unsigned BIT_COUNT = DEFAULT_BIT_COUNT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 is_enabled,
    input  logic                 start,
    input  logic                 stop,
    input  logic [BIT_COUNT-1:0] load_value,
    input  logic                 is_periodic,
    output logic [BIT_COUNT-1:0] count,
    output logic                 done,
    output logic                 is_running,
    output logic                 is_expired
);

    timer_state_t         state;
    timer_state_t         state_next;
    timer_mode_t          mode;
    logic [BIT_COUNT-1:0] terminal;
    logic [BIT_COUNT-1:0] count_next;
    logic                 done_next;
    logic                 at_terminal;
    logic                 advance;

    assign at_terminal = (count == terminal);
    assign advance     = (state == STATE_RUNNING) && is_enabled;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= STATE_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // stop outranks start; both outrank the enable gate
    always_comb begin
        state_next = state;
        if (stop) begin
            state_next = STATE_IDLE;
        end else if (start) begin
            state_next = STATE_RUNNING;
        end else begin
            case (state)
                STATE_RUNNING: begin
                    if (is_enabled && at_terminal
                        && mode == MODE_ONE_SHOT) begin
                        state_next = STATE_EXPIRED;
                    end
                end
                STATE_IDLE:    state_next = STATE_IDLE;
                STATE_EXPIRED: state_next = STATE_EXPIRED;
                default:       state_next = STATE_IDLE;
            endcase
        end
    end

    always_comb begin
        is_running = (state == STATE_RUNNING);
        is_expired = (state == STATE_EXPIRED);
    end

    // increment only below terminal, so the adder can never wrap
    always_comb begin
        count_next = count;
        done_next  = 1'b0;
        if (!at_terminal) begin
            count_next = count + BIT_COUNT'(1);
            done_next  = (count_next == terminal);
        end else if (mode == MODE_PERIODIC) begin
            count_next = '0;
            done_next  = (terminal == '0);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            terminal <= '0;
            mode     <= MODE_ONE_SHOT;
            count    <= '0;
            done     <= 1'b0;
        end else if (stop) begin
            count <= '0;
            done  <= 1'b0;
        end else if (start) begin
            terminal <= load_value;
            mode     <= is_periodic ? MODE_PERIODIC
                                    : MODE_ONE_SHOT;
            count    <= '0;
            done     <= (load_value == '0);
        end else if (advance) begin
            count <= count_next;
            done  <= done_next;
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_programmable_timer.sv
// Bench for programmable_timer: vector table, directed corner sequences,
// and randomized traffic against an elapsed-cycle reference model.
module tb_programmable_timer;

    localparam int W  = 32;
    localparam int SW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          is_enabled = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [W-1:0]  load_value = '0;
    logic          is_periodic = 1'b0;
    logic [W-1:0]  count;
    logic          done;
    logic          is_running;
    logic          is_expired;

    logic          s_en = 1'b0;
    logic          s_start = 1'b0;
    logic          s_stop = 1'b0;
    logic [SW-1:0] s_lv = '0;
    logic          s_per = 1'b0;
    logic [SW-1:0] s_count;
    logic          s_done;
    logic          s_run;
    logic          s_exp;

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    programmable_timer #(.BIT_COUNT(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .is_enabled (is_enabled),
        .start      (start),
        .stop       (stop),
        .load_value (load_value),
        .is_periodic(is_periodic),
        .count      (count),
        .done       (done),
        .is_running (is_running),
        .is_expired (is_expired)
    );

    programmable_timer #(.BIT_COUNT(SW)) dut_small (
        .clock      (clock),
        .reset      (reset),
        .is_enabled (s_en),
        .start      (s_start),
        .stop       (s_stop),
        .load_value (s_lv),
        .is_periodic(s_per),
        .count      (s_count),
        .done       (s_done),
        .is_running (s_run),
        .is_expired (s_exp)
    );

    // reference: a run is "elapsed enabled cycles since start"
    bit              m_active;
    bit              m_per;
    bit              m_fresh;
    longint unsigned m_term;
    longint unsigned m_elapsed;

    function automatic void model_reset();
        m_active  = 1'b0;
        m_per     = 1'b0;
        m_fresh   = 1'b0;
        m_term    = 0;
        m_elapsed = 0;
    endfunction

    function automatic void model_edge();
        if (stop) begin
            m_active = 1'b0;
            m_fresh  = 1'b0;
        end else if (start) begin
            m_active  = 1'b1;
            m_term    = longint'(load_value);
            m_per     = is_periodic;
            m_elapsed = 0;
            m_fresh   = 1'b1;
        end else if (m_active && is_enabled
                     && (m_per || m_elapsed <= m_term)) begin
            m_elapsed = m_elapsed + 1;
            m_fresh   = 1'b1;
        end else begin
            m_fresh = 1'b0;
        end
    endfunction

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0d, required %0d at %0t",
                      name, act, req, $time);
    endtask

    task automatic check_model();
        longint unsigned c;
        bit d, r, x;
        c = 0; d = 0; r = 0; x = 0;
        if (m_active && m_per) begin
            c = m_elapsed % (m_term + 1);
            r = 1'b1;
            d = m_fresh && (c == m_term);
        end else if (m_active) begin
            x = (m_elapsed > m_term);
            r = !x;
            c = x ? m_term : m_elapsed;
            d = m_fresh && (m_elapsed == m_term);
        end
        check("rand count", 64'(count), c);
        check("rand done", 64'(done), 64'(d));
        check("rand is_running", 64'(is_running), 64'(r));
        check("rand is_expired", 64'(is_expired), 64'(x));
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit st, input bit sp, input bit en,
                         input logic [W-1:0] lv, input bit per);
        start       = st;
        stop        = sp;
        is_enabled  = en;
        load_value  = lv;
        is_periodic = per;
    endtask

    task automatic check_outs(input string tag, input logic [W-1:0] c,
                              input bit d, input bit r, input bit x);
        check({tag, " count"}, 64'(count), 64'(c));
        check({tag, " done"}, 64'(done), 64'(d));
        check({tag, " is_running"}, 64'(is_running), 64'(r));
        check({tag, " is_expired"}, 64'(is_expired), 64'(x));
    endtask

    typedef struct {
        bit           st;
        bit           sp;
        bit           en;
        logic [W-1:0] lv;
        bit           per;
        logic [W-1:0] c;
        bit           d;
        bit           r;
        bit           x;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // periodic 3, ignored reload changes, stop, start+stop, load 0
        vecs.push_back('{1, 0, 1, 3, 1, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 1, 3, 1, 1, 0, 1, 0});
        vecs.push_back('{0, 0, 1, 3, 1, 2, 0, 1, 0});
        vecs.push_back('{0, 0, 1, 3, 1, 3, 1, 1, 0});
        vecs.push_back('{0, 0, 1, 3, 1, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 1, 3, 1, 1, 0, 1, 0});
        vecs.push_back('{0, 0, 1, 3, 1, 2, 0, 1, 0});
        vecs.push_back('{0, 0, 1, 3, 1, 3, 1, 1, 0});
        vecs.push_back('{0, 0, 1, 9, 0, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 1, 9, 0, 1, 0, 1, 0});
        vecs.push_back('{0, 1, 1, 9, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 1, 1, 5, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 5, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 0, 1, 0, 0, 0, 1, 1, 0});
        vecs.push_back('{0, 0, 1, 0, 0, 0, 0, 0, 1});
        vecs.push_back('{0, 0, 1, 0, 0, 0, 0, 0, 1});
        vecs.push_back('{1, 0, 1, 0, 1, 0, 1, 1, 0});
        vecs.push_back('{0, 0, 1, 0, 1, 0, 1, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 1, 0, 1, 0, 1, 1, 0});

        model_reset();
        #1 reset = 1'b1;
        #1;
        check_outs("reset", 0, 0, 0, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].sp, vecs[i].en,
                  vecs[i].lv, vecs[i].per);
            step();
            check_outs($sformatf("vec[%0d]", i), vecs[i].c,
                       vecs[i].d, vecs[i].r, vecs[i].x);
        end

        // one-shot 18: done exactly with count 18, then expire and hold
        drive(1, 0, 1, 18, 0);
        step();
        check_outs("os18 start", 0, 0, 1, 0);
        drive(0, 0, 1, 18, 0);
        for (int i = 1; i <= 18; i++) begin
            step();
            check_outs($sformatf("os18 c%0d", i), W'(i),
                       (i == 18), 1, 0);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            check_outs("os18 hold", 18, 0, 0, 1);
        end

        // one-shot 10 frozen for 5 cycles at count 4
        drive(1, 0, 1, 10, 0);
        step();
        drive(0, 0, 1, 10, 0);
        repeat (4) step();
        check_outs("frz pre", 4, 0, 1, 0);
        is_enabled = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_outs("frz hold", 4, 0, 1, 0);
        end
        is_enabled = 1'b1;
        repeat (5) step();
        check_outs("frz c9", 9, 0, 1, 0);
        step();
        check_outs("frz c10", 10, 1, 1, 0);
        is_enabled = 1'b0;
        step();
        check_outs("frz at term", 10, 0, 1, 0);

        // restart mid-run, then stop at count 7
        drive(1, 0, 1, 20, 0);
        step();
        drive(0, 0, 1, 20, 0);
        repeat (3) step();
        drive(1, 0, 1, 2, 0);
        step();
        check_outs("restart", 0, 0, 1, 0);
        drive(0, 0, 1, 20, 0);
        step();
        step();
        check_outs("restart done", 2, 1, 1, 0);
        drive(1, 0, 1, 20, 0);
        step();
        drive(0, 0, 1, 20, 0);
        repeat (7) step();
        check_outs("stop pre", 7, 0, 1, 0);
        stop = 1'b1;
        step();
        check_outs("stop", 0, 0, 0, 0);
        stop = 1'b0;
        step();
        check_outs("stop idle", 0, 0, 0, 0);

        // held start keeps count at 0
        drive(1, 0, 1, 4, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            check_outs("held start", 0, 0, 1, 0);
        end

        // async reset between edges at count 12
        drive(1, 0, 1, 14, 0);
        step();
        drive(0, 0, 1, 14, 0);
        repeat (12) step();
        check_outs("rst pre", 12, 0, 1, 0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        #1;
        check_outs("rst async", 0, 0, 0, 0);
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_outs("rst after", 0, 0, 0, 0);
        end
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        #1 reset = 1'b0;
        drive(1, 0, 1, 5, 1);
        step();
        check_outs("rst first edge", 0, 0, 1, 0);
        drive(0, 0, 1, 5, 1);

        // narrow instance at all-ones terminal
        s_start = 1'b1; s_lv = 4'hF; s_per = 1'b1; s_en = 1'b1;
        step();
        s_start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            check("max per count", 64'(s_count), 64'(i % 16));
            check("max per done", 64'(s_done), 64'(i == 15));
        end
        check("max per run", 64'(s_run), 64'(1));
        s_start = 1'b1; s_per = 1'b0;
        step();
        s_start = 1'b0;
        repeat (17) step();
        check("max os count", 64'(s_count), 64'(15));
        check("max os exp", 64'(s_exp), 64'(1));
        s_en = 1'b0;

        // randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            int unsigned pick;
            start       = ($urandom_range(0, 99) < 6);
            stop        = ($urandom_range(0, 99) < 3);
            is_enabled  = ($urandom_range(0, 99) < 85);
            is_periodic = $urandom_range(0, 1) == 1;
            pick = $urandom_range(0, 9);
            if (pick == 0) load_value = '0;
            else if (pick == 1) load_value = '1;
            else load_value = W'($urandom_range(1, 20));
            step();
            check_model();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
